mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 32-bit system RAM between the CPU memory path (MAR/MDR,
//  driven by the control unit's Read/write_mem) and the program-loader/debug port.
//  Serialises requests, runs the RAM read wait states, returns data with a one-cycle
//  ack, and holds the control-unit FSM via cpu_stall until its access completes.
// PARAMETERS
//  ADDR_W   9   RAM word-address width (512 words)
//  DATA_W   32  data width
//  RAM_LAT  1   RAM read latency in cycles (>=1); ram_rdata valid RAM_LAT cycles after the address
// PORTS
//  clk        in   1       system clock, all state on rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  cpu_req    in   1       CPU access request; held until cpu_ack
//  cpu_we     in   1       1=write, 0=read; stable while cpu_req=1
//  cpu_addr   in   ADDR_W  CPU word address (MAR)
//  cpu_wdata  in   DATA_W  CPU write data (MDR)
//  cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1
//  cpu_ack    out  1       one-cycle completion pulse
//  cpu_stall  out  1       cpu_req & ~cpu_ack (combinational); freezes control-unit state
//  ld_req     in   1       loader access request; held until ld_ack
//  ld_we      in   1       loader write enable
//  ld_addr    in   ADDR_W  loader word address
//  ld_wdata   in   DATA_W  loader write data
//  ld_rdata   out  DATA_W  read data, valid while ld_ack=1
//  ld_ack     out  1       one-cycle completion pulse
//  ld_lock    in   1       1 = CPU locked out (program load); CPU not granted new accesses
//  ram_addr   out  ADDR_W  RAM address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_we     out  1       RAM write strobe, exactly one cycle per write
//  ram_rdata  in   DATA_W  RAM read data
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; all acks, ram_we=0; ram_addr, ram_wdata,
//   cpu_rdata, ld_rdata = 0; last_grant=LD (so the CPU wins the first tie). No ack issued
//   for a transaction aborted by reset; requester must re-request.
//  FSM: IDLE -> ISSUE -> (read) WAIT -> RESP -> IDLE ; (write) ISSUE -> RESP -> IDLE.
//   IDLE : sample requests; if any eligible, latch winner id, addr, we, wdata; ->ISSUE.
//   ISSUE: ram_addr=latched addr; ram_we=latched we; ram_wdata=latched data. Write ->RESP.
//          Read -> WAIT, cnt=RAM_LAT.
//   WAIT : cnt--; when cnt==1 latch ram_rdata into winner's rdata reg; ->RESP.
//   RESP : assert winner's ack for one cycle, rdata held; ram_we=0; ->IDLE.
//  Latency (req seen in IDLE at cycle 0): write ack in cycle 2; read ack in cycle 2+RAM_LAT.
//  Eligibility: ld_req always; cpu_req only when ld_lock=0.
//  Arbitration: single eligible requester wins. Both eligible -> round robin: grant
//   the port not in last_grant; last_grant updates on every grant.
//  ld_lock rising mid CPU transaction: that transaction completes normally; lock only
//   blocks subsequent grants.
//  Requests sampled only in IDLE; req dropped before ack = protocol violation (assertion);
//   latched copy still completes, ack still pulses.
//  Requester deasserts req the cycle after ack; IDLE after RESP sees no stale request.
//  ram_addr holds last value outside ISSUE; ram_we high only in ISSUE of a write.
//  rdata registers hold last read value until next read for that port.
//  Back-to-back: a requester re-asserting immediately is served again only if the
//   other port is idle (fairness: never two consecutive grants while other waits).
// STRUCTURE
//  Package mem_arb_pkg: state enum {IDLE, ISSUE, WAIT, RESP}, port ids PORT_CPU=0,
//   PORT_LD=1, localparam width of cnt = $clog2(RAM_LAT+1).
//  Sub-module rr_arbiter2: combinational 2-way round-robin picker
//   (req[1:0], last_grant -> grant_valid, grant_id). Everything else in the top.
// TESTING
//  CPU read addr 0x010 (RAM holds 0xDEADBEEF), RAM_LAT=1 -> cpu_ack in cycle 3, cpu_rdata=0xDEADBEEF.
//  CPU write 0x12345678 to 0x1FF -> ram_we one cycle in cycle 1, cpu_ack cycle 2; readback matches.
//  cpu_req and ld_req both high, continuous -> grants alternate CPU,LD,CPU,LD; no port starved.
//  ld_lock=1, 8 loader writes 0x000..0x007 while cpu_req=1 -> cpu_stall=1 throughout, zero cpu_acks;
//   drop lock -> CPU served within 3 cycles.
//  reset_n low during WAIT of a CPU read -> ram_we=0, no acks, state IDLE; request retried ok.
//  RAM_LAT=3 loader read -> ld_ack exactly cycle 5; ld_lock toggled mid-CPU-read -> read completes.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the system-RAM arbiter: FSM states, port ids and counter sizing.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LD  = 1'b1
    } port_t;

    // Wait-state counter must hold RAM_LAT itself, hence the +1.
    function automatic int cnt_width(input int ram_lat);
        return $clog2(ram_lat + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port
// that was not granted last.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_t      last_grant,
    output logic       grant_valid,
    output port_t      grant_id
);

    always_comb begin
        grant_valid = |req;
        grant_id    = PORT_CPU;
        if (req[PORT_LD] && req[PORT_CPU]) begin
            grant_id = (last_grant == PORT_CPU) ? PORT_LD : PORT_CPU;
        end else if (req[PORT_LD]) begin
            grant_id = PORT_LD;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU and loader accesses onto the single-port system RAM, runs the
// read wait states and stalls the CPU control unit until its access completes.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ack,
    input  logic              ld_lock,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CNT_W = cnt_width(RAM_LAT);

    state_t            state_reg, state_next;
    port_t             win_id_reg, last_grant_reg;
    logic              win_we_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] ram_addr_reg;
    logic [DATA_W-1:0] ram_wdata_reg;
    logic              ram_we_reg;
    logic              grant_valid;
    port_t             grant_id;
    logic              to_resp;
    logic              rdata_capture;

    // A locked-out CPU is simply not eligible; the loader always is.
    rr_arbiter2 u_rr (
        .req         ({ld_req, cpu_req & ~ld_lock}),
        .last_grant  (last_grant_reg),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   state_next = win_we_reg ? RESP : WAIT;
            WAIT:    if (cnt_reg == CNT_W'(1)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign to_resp       = (state_reg != RESP) && (state_next == RESP);
    assign rdata_capture = (state_reg == WAIT) && (cnt_reg == CNT_W'(1));

    // RAM-side outputs are loaded on the grant edge so they are valid throughout ISSUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            win_id_reg     <= PORT_CPU;
            last_grant_reg <= PORT_LD;
            win_we_reg     <= 1'b0;
            cnt_reg        <= '0;
            ram_addr_reg   <= '0;
            ram_wdata_reg  <= '0;
            ram_we_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ram_we_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        win_id_reg     <= grant_id;
                        last_grant_reg <= grant_id;
                        if (grant_id == PORT_LD) begin
                            win_we_reg    <= ld_we;
                            ram_we_reg    <= ld_we;
                            ram_addr_reg  <= ld_addr;
                            ram_wdata_reg <= ld_wdata;
                        end else begin
                            win_we_reg    <= cpu_we;
                            ram_we_reg    <= cpu_we;
                            ram_addr_reg  <= cpu_addr;
                            ram_wdata_reg <= cpu_wdata;
                        end
                    end
                end
                ISSUE:   cnt_reg <= CNT_W'(RAM_LAT);
                WAIT:    cnt_reg <= cnt_reg - CNT_W'(1);
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            localparam port_t PID = port_t'(gi);
            logic              ack_reg;
            logic [DATA_W-1:0] rdata_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= to_resp && (win_id_reg == PID);
                    if (rdata_capture && (win_id_reg == PID)) begin
                        rdata_reg <= ram_rdata;
                    end
                end
            end
        end
    endgenerate

    assign cpu_ack   = g_port[0].ack_reg;
    assign cpu_rdata = g_port[0].rdata_reg;
    assign ld_ack    = g_port[1].ack_reg;
    assign ld_rdata  = g_port[1].rdata_reg;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign ram_we    = ram_we_reg;

    // Requesters must hold req until their ack; the latched copy completes regardless.
    a_cpu_req_held: assert property (@(posedge clk) disable iff (!reset_n)
        ((state_reg == ISSUE || state_reg == WAIT) && win_id_reg == PORT_CPU) |-> cpu_req);
    a_ld_req_held: assert property (@(posedge clk) disable iff (!reset_n)
        ((state_reg == ISSUE || state_reg == WAIT) && win_id_reg == PORT_LD) |-> ld_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with RAM_LAT=1, one with RAM_LAT=3,
// each backed by a simple latency-matched RAM model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    int          total = 0;
    int          bad   = 0;

    // Instance with RAM_LAT=1
    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata, cpu_rdata;
    logic        ld_req, ld_we, ld_ack, ld_lock;
    logic [8:0]  ld_addr;
    logic [31:0] ld_wdata, ld_rdata;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_we;

    // Instance with RAM_LAT=3
    logic        cpu_req3, cpu_we3, cpu_ack3, cpu_stall3;
    logic [8:0]  cpu_addr3;
    logic [31:0] cpu_wdata3, cpu_rdata3;
    logic        ld_req3, ld_we3, ld_ack3, ld_lock3;
    logic [8:0]  ld_addr3;
    logic [31:0] ld_wdata3, ld_rdata3;
    logic [8:0]  ram_addr3;
    logic [31:0] ram_wdata3, ram_rdata3;
    logic        ram_we3;

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_rdata(ld_rdata), .ld_ack(ld_ack), .ld_lock(ld_lock),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .RAM_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
        .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3), .cpu_stall(cpu_stall3),
        .ld_req(ld_req3), .ld_we(ld_we3), .ld_addr(ld_addr3), .ld_wdata(ld_wdata3),
        .ld_rdata(ld_rdata3), .ld_ack(ld_ack3), .ld_lock(ld_lock3),
        .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_we(ram_we3), .ram_rdata(ram_rdata3)
    );

    // RAM models: data valid RAM_LAT cycles after the address is presented.
    logic [31:0] mem1 [512];
    logic [31:0] mem3 [512];
    logic [31:0] rd1_q;
    logic [31:0] p3 [3];

    always @(posedge clk) begin
        if (ram_we) mem1[ram_addr] <= ram_wdata;
        rd1_q <= mem1[ram_addr];
        if (ram_we3) mem3[ram_addr3] <= ram_wdata3;
        p3[0] <= mem3[ram_addr3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign ram_rdata  = rd1_q;
    assign ram_rdata3 = p3[2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One access on the RAM_LAT=1 instance, started at a negedge in IDLE (cycle 0).
    task automatic xfer(input bit is_ld, input bit we, input logic [8:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output int ack_cyc, output int we_cnt, output int we_cyc,
                        output logic [8:0] issue_addr, output int nostall, output int cpu_acks);
        if (is_ld) begin
            ld_req = 1'b1; ld_we = we; ld_addr = addr; ld_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        rdata = '0; ack_cyc = -1; we_cnt = 0; we_cyc = -1; issue_addr = '0;
        nostall = 0; cpu_acks = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) issue_addr = ram_addr;
            if (ram_we) begin
                we_cnt++;
                if (we_cyc < 0) we_cyc = k;
            end
            if (!cpu_stall) nostall++;
            if (cpu_ack) cpu_acks++;
            if (is_ld ? ld_ack : cpu_ack) begin
                ack_cyc = k;
                rdata   = is_ld ? ld_rdata : cpu_rdata;
                break;
            end
        end
        if (is_ld) ld_req = 1'b0;
        else       cpu_req = 1'b0;
        $display("txn port=%s we=%0d addr=0x%03h wdata=0x%08h rdata=0x%08h ack_cycle=%0d",
                 is_ld ? "LD" : "CPU", we, addr, wdata, rdata, ack_cyc);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [8:0]  ia;
        int          ac, wc, wy, ns, ca, tot_ns, tot_ca;
        int          order[$];

        for (int i = 0; i < 512; i++) begin
            mem1[i] = '0;
            mem3[i] = '0;
        end
        mem1[9'h010] = 32'hDEADBEEF;
        mem3[9'h005] = 32'h55AA55AA;
        mem3[9'h006] = 32'h06060606;

        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_lock = 0;
        cpu_req3 = 0; cpu_we3 = 0; cpu_addr3 = '0; cpu_wdata3 = '0;
        ld_req3 = 0; ld_we3 = 0; ld_addr3 = '0; ld_wdata3 = '0; ld_lock3 = 0;
        repeat (3) @(negedge clk);

        check("rst_cpu_ack", cpu_ack, 0);
        check("rst_ld_ack", ld_ack, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_ld_rdata", ld_rdata, 0);
        check("rst_stall", cpu_stall, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // CPU read: ack in cycle 3 with RAM_LAT=1
        xfer(0, 0, 9'h010, '0, rd, ac, wc, wy, ia, ns, ca);
        check("cpu_rd_data", rd, 32'hDEADBEEF);
        check("cpu_rd_ack_cyc", ac, 3);
        check("cpu_rd_issue_addr", ia, 9'h010);
        check("cpu_rd_no_we", wc, 0);

        // CPU write: one-cycle ram_we in cycle 1, ack cycle 2
        xfer(0, 1, 9'h1FF, 32'h12345678, rd, ac, wc, wy, ia, ns, ca);
        check("cpu_wr_we_cyc", wy, 1);
        check("cpu_wr_we_cnt", wc, 1);
        check("cpu_wr_ack_cyc", ac, 2);
        check("cpu_wr_ram", mem1[9'h1FF], 32'h12345678);
        xfer(0, 0, 9'h1FF, '0, rd, ac, wc, wy, ia, ns, ca);
        check("cpu_readback", rd, 32'h12345678);

        // Loader write and read; CPU rdata must hold its last value
        xfer(1, 1, 9'h020, 32'hAABBCCDD, rd, ac, wc, wy, ia, ns, ca);
        check("ld_wr_ack_cyc", ac, 2);
        xfer(1, 0, 9'h020, '0, rd, ac, wc, wy, ia, ns, ca);
        check("ld_rd_data", rd, 32'hAABBCCDD);
        check("ld_rd_ack_cyc", ac, 3);
        check("cpu_rdata_hold", cpu_rdata, 32'h12345678);

        // Both requesting continuously: CPU,LD,CPU,LD,CPU at cycles 3,7,11,15,19
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        ld_req = 1; ld_we = 0; ld_addr = 9'h020;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (cpu_ack && ld_ack) order.push_back(2);
            else if (cpu_ack) order.push_back(0);
            else if (ld_ack) order.push_back(1);
        end
        cpu_req = 0; ld_req = 0;
        @(negedge clk);
        $display("txn port=BOTH grants=%0d", order.size());
        check("rr_grant_count", order.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) check($sformatf("rr_grant_%0d", i), order[i], i % 2);
        end
        check("rr_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check("rr_ld_rdata", ld_rdata, 32'hAABBCCDD);

        // Lock: CPU stalled through 8 loader writes, then served once lock drops
        ld_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        tot_ns = 0; tot_ca = 0;
        for (int i = 0; i < 8; i++) begin
            xfer(1, 1, 9'(i), 32'h11 * i + 32'h100, rd, ac, wc, wy, ia, ns, ca);
            tot_ns += ns;
            tot_ca += ca;
            check($sformatf("lock_ld_ack_%0d", i), ac, 2);
        end
        check("lock_stall_low_cycles", tot_ns, 0);
        check("lock_cpu_acks", tot_ca, 0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("lock_ram_%0d", i), mem1[i], 32'h11 * i + 32'h100);
        end
        ld_lock = 0;
        xfer(0, 0, 9'h010, '0, rd, ac, wc, wy, ia, ns, ca);
        check("unlock_cpu_ack_cyc", ac, 3);
        check("unlock_cpu_data", rd, 32'hDEADBEEF);

        // Reset during WAIT of a CPU read aborts it; a retry completes
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h1FF;
        @(negedge clk);
        @(negedge clk);
        reset_n = 0;
        #1;
        check("abort_ram_we", ram_we, 0);
        check("abort_ram_addr", ram_addr, 0);
        check("abort_cpu_ack", cpu_ack, 0);
        @(negedge clk);
        check("abort_cpu_ack_hold", cpu_ack, 0);
        check("abort_ld_ack", ld_ack, 0);
        check("abort_cpu_rdata", cpu_rdata, 0);
        reset_n = 1;
        xfer(0, 0, 9'h1FF, '0, rd, ac, wc, wy, ia, ns, ca);
        check("retry_ack_cyc", ac, 3);
        check("retry_data", rd, 32'h12345678);

        // RAM_LAT=3: loader read acks in cycle 5
        ld_req3 = 1; ld_we3 = 0; ld_addr3 = 9'h005;
        ac = -1; rd = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ld_ack3) begin
                ac = k;
                rd = ld_rdata3;
                break;
            end
        end
        ld_req3 = 0;
        @(negedge clk);
        $display("txn lat3 port=LD addr=0x005 rdata=0x%08h ack_cycle=%0d", rd, ac);
        check("lat3_ld_ack_cyc", ac, 5);
        check("lat3_ld_data", rd, 32'h55AA55AA);

        // RAM_LAT=3: lock raised mid CPU read does not disturb it
        cpu_req3 = 1; cpu_we3 = 0; cpu_addr3 = 9'h006;
        ac = -1; rd = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) ld_lock3 = 1;
            if (cpu_ack3) begin
                ac = k;
                rd = cpu_rdata3;
                break;
            end
        end
        cpu_req3 = 0; ld_lock3 = 0;
        @(negedge clk);
        $display("txn lat3 port=CPU addr=0x006 rdata=0x%08h ack_cycle=%0d", rd, ac);
        check("lat3_lock_cpu_ack_cyc", ac, 5);
        check("lat3_lock_cpu_data", rd, 32'h06060606);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
